// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Pipeline hazard controller for the RV32I core. It watches the register and
// CSR addresses in the ID/EX, EX/MEM and MEM/WB segment registers and decides:
//   - which segment registers hold (bubbleX) or clear (flushX) this cycle,
//   - where the EX stage takes its operands and CSR value from (forwarding),
//   - how long a multi-cycle mul/div instruction keeps EX occupied.
//
// Parameters:
//   MD_LAT         cycles a mul/div occupies EX (1..16)
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   reg1/2_src_ID, reg1/2_read_ID ID source registers and their read enables
//   reg1/2_src_EX, reg_dest_EX    ID/EX register addresses
//   load_EX                       EX instruction is a load
//   reg_dest_MEM/WB, reg_write_*  MEM/WB destination and write enable
//   csr_src_EX, csr_dest_MEM/WB   CSR addresses
//   csr_write_MEM/WB              MEM/WB instruction writes a CSR
//   br_EX, jalr_EX, jal_ID        control-flow redirects
//   md_start_EX                   mul/div instruction in EX
//   dcache_miss                   data cache miss in MEM (level, held)
//   bubbleF..W, flushF..W         segment register hold / clear
//   op1_sel, op2_sel, csr_sel     EX source select (0 file, 1 MEM, 2 WB)
//   md_done                       one-cycle pulse in the mul/div release cycle
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int MD_LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  reg1_src_ID,
  input  logic [4:0]  reg2_src_ID,
  input  logic        reg1_read_ID,
  input  logic        reg2_read_ID,
  input  logic [4:0]  reg1_src_EX,
  input  logic [4:0]  reg2_src_EX,
  input  logic [4:0]  reg_dest_EX,
  input  logic        load_EX,
  input  logic [4:0]  reg_dest_MEM,
  input  logic [4:0]  reg_dest_WB,
  input  logic        reg_write_MEM,
  input  logic        reg_write_WB,
  input  logic [11:0] csr_src_EX,
  input  logic [11:0] csr_dest_MEM,
  input  logic [11:0] csr_dest_WB,
  input  logic        csr_write_MEM,
  input  logic        csr_write_WB,
  input  logic        br_EX,
  input  logic        jalr_EX,
  input  logic        jal_ID,
  input  logic        md_start_EX,
  input  logic        dcache_miss,
  output logic        bubbleF,
  output logic        bubbleD,
  output logic        bubbleE,
  output logic        bubbleM,
  output logic        bubbleW,
  output logic        flushF,
  output logic        flushD,
  output logic        flushE,
  output logic        flushM,
  output logic        flushW,
  output logic [1:0]  op1_sel,
  output logic [1:0]  op2_sel,
  output logic [1:0]  csr_sel,
  output logic        md_done
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Forwarding select encoding shared by operand and CSR paths.
  localparam logic [1:0] SEL_FILE = 2'd0;
  localparam logic [1:0] SEL_MEM  = 2'd1;
  localparam logic [1:0] SEL_WB   = 2'd2;

  // The first EX cycle is spent in IDLE, so the counter covers the remaining
  // MD_LAT-1 cycles, the last of which (cnt == 0) is the release cycle.
  localparam bit          MD_MULTI   = (MD_LAT > 1);
  localparam int          CNT_INIT_I = MD_MULTI ? (MD_LAT - 2) : 0;
  localparam logic [3:0]  CNT_INIT   = CNT_INIT_I[3:0];

  state_t     r_state;
  logic [3:0] r_cnt;

  logic w_md_hold;
  logic w_redirect;
  logic w_load_use;

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
  assign w_md_hold  = ((r_state == BUSY) && (r_cnt != 4'd0)) ||
                      ((r_state == IDLE) && md_start_EX && MD_MULTI);

  assign w_redirect = br_EX | jalr_EX;

  assign w_load_use = load_EX && (reg_dest_EX != 5'd0) &&
                      ((reg1_read_ID && (reg1_src_ID == reg_dest_EX)) ||
                       (reg2_read_ID && (reg2_src_ID == reg_dest_EX)));

  // Release cycle: BUSY with the counter exhausted. A cache miss freezes the
  // FSM, so the pulse waits until the miss clears to avoid issuing it twice.
  assign md_done = !rst && !dcache_miss && (r_state == BUSY) && (r_cnt == 4'd0);

  // ---------------------------------------------------------------------------
  // Stall / flush priority
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output gets a default before the priority chain so no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    bubbleF = 1'b0;
    bubbleD = 1'b0;
    bubbleE = 1'b0;
    bubbleM = 1'b0;
    bubbleW = 1'b0;
    flushF  = 1'b0;
    flushD  = 1'b0;
    flushE  = 1'b0;
    flushM  = 1'b0;
    flushW  = 1'b0;

    if (rst) begin
      flushF = 1'b1;
      flushD = 1'b1;
      flushE = 1'b1;
      flushM = 1'b1;
      flushW = 1'b1;
    end else if (dcache_miss) begin
      // Everything up to MEM waits for the data; WB takes a bubble.
      bubbleF = 1'b1;
      bubbleD = 1'b1;
      bubbleE = 1'b1;
      bubbleM = 1'b1;
      flushW  = 1'b1;
    end else if (w_md_hold) begin
      // Mul/div keeps EX; MEM receives a bubble instead of a partial result.
      bubbleF = 1'b1;
      bubbleD = 1'b1;
      bubbleE = 1'b1;
      flushM  = 1'b1;
    end else if (w_redirect) begin
      flushD = 1'b1;
      flushE = 1'b1;
    end else if (w_load_use) begin
      bubbleF = 1'b1;
      bubbleD = 1'b1;
      flushE  = 1'b1;
    end else if (jal_ID) begin
      flushD = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Forwarding
  // ---------------------------------------------------------------------------
  function automatic logic [1:0] reg_fwd(input logic [4:0] src);
    if (reg_write_MEM && (reg_dest_MEM != 5'd0) && (reg_dest_MEM == src))
      return SEL_MEM;
    else if (reg_write_WB && (reg_dest_WB != 5'd0) && (reg_dest_WB == src))
      return SEL_WB;
    else
      return SEL_FILE;
  endfunction

  // CSR address 0 is a real CSR, so no zero exclusion here.
  function automatic logic [1:0] csr_fwd(input logic [11:0] src);
    if (csr_write_MEM && (csr_dest_MEM == src))
      return SEL_MEM;
    else if (csr_write_WB && (csr_dest_WB == src))
      return SEL_WB;
    else
      return SEL_FILE;
  endfunction

  assign op1_sel = rst ? SEL_FILE : reg_fwd(reg1_src_EX);
  assign op2_sel = rst ? SEL_FILE : reg_fwd(reg2_src_EX);
  assign csr_sel = rst ? SEL_FILE : csr_fwd(csr_src_EX);

  // ---------------------------------------------------------------------------
  // Mul/div FSM
  // ---------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else if (!dcache_miss) begin
      case (r_state)
        IDLE: begin
          if (md_start_EX && MD_MULTI) begin
            r_state <= BUSY;
            r_cnt   <= CNT_INIT;
          end
        end
        BUSY: begin
          // md_start_EX is still high in the release cycle; it is ignored here.
          if (r_cnt != 4'd0)
            r_cnt <= r_cnt - 4'd1;
          else
            r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Directed bench for hazard_ctrl. One instance uses MD_LAT = 4, a second one
// shares the same inputs with MD_LAT = 1. Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  reg1_src_ID, reg2_src_ID;
  logic        reg1_read_ID, reg2_read_ID;
  logic [4:0]  reg1_src_EX, reg2_src_EX, reg_dest_EX;
  logic        load_EX;
  logic [4:0]  reg_dest_MEM, reg_dest_WB;
  logic        reg_write_MEM, reg_write_WB;
  logic [11:0] csr_src_EX, csr_dest_MEM, csr_dest_WB;
  logic        csr_write_MEM, csr_write_WB;
  logic        br_EX, jalr_EX, jal_ID;
  logic        md_start_EX;
  logic        dcache_miss;

  logic        bubbleF, bubbleD, bubbleE, bubbleM, bubbleW;
  logic        flushF, flushD, flushE, flushM, flushW;
  logic [1:0]  op1_sel, op2_sel, csr_sel;
  logic        md_done;

  logic        b1F, b1D, b1E, b1M, b1W;
  logic        f1F, f1D, f1E, f1M, f1W;
  logic [1:0]  o1_1, o1_2, c1_sel;
  logic        md_done1;

  logic [4:0]  bub, fl, bub1, fl1;
  assign bub  = {bubbleF, bubbleD, bubbleE, bubbleM, bubbleW};
  assign fl   = {flushF, flushD, flushE, flushM, flushW};
  assign bub1 = {b1F, b1D, b1E, b1M, b1W};
  assign fl1  = {f1F, f1D, f1E, f1M, f1W};

  int n_tests;
  int n_fail;

  hazard_ctrl #(.MD_LAT(4)) u_dut (
    .clk(clk), .rst(rst),
    .reg1_src_ID(reg1_src_ID), .reg2_src_ID(reg2_src_ID),
    .reg1_read_ID(reg1_read_ID), .reg2_read_ID(reg2_read_ID),
    .reg1_src_EX(reg1_src_EX), .reg2_src_EX(reg2_src_EX),
    .reg_dest_EX(reg_dest_EX), .load_EX(load_EX),
    .reg_dest_MEM(reg_dest_MEM), .reg_dest_WB(reg_dest_WB),
    .reg_write_MEM(reg_write_MEM), .reg_write_WB(reg_write_WB),
    .csr_src_EX(csr_src_EX), .csr_dest_MEM(csr_dest_MEM),
    .csr_dest_WB(csr_dest_WB), .csr_write_MEM(csr_write_MEM),
    .csr_write_WB(csr_write_WB),
    .br_EX(br_EX), .jalr_EX(jalr_EX), .jal_ID(jal_ID),
    .md_start_EX(md_start_EX), .dcache_miss(dcache_miss),
    .bubbleF(bubbleF), .bubbleD(bubbleD), .bubbleE(bubbleE),
    .bubbleM(bubbleM), .bubbleW(bubbleW),
    .flushF(flushF), .flushD(flushD), .flushE(flushE),
    .flushM(flushM), .flushW(flushW),
    .op1_sel(op1_sel), .op2_sel(op2_sel), .csr_sel(csr_sel),
    .md_done(md_done)
  );

  hazard_ctrl #(.MD_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .reg1_src_ID(reg1_src_ID), .reg2_src_ID(reg2_src_ID),
    .reg1_read_ID(reg1_read_ID), .reg2_read_ID(reg2_read_ID),
    .reg1_src_EX(reg1_src_EX), .reg2_src_EX(reg2_src_EX),
    .reg_dest_EX(reg_dest_EX), .load_EX(load_EX),
    .reg_dest_MEM(reg_dest_MEM), .reg_dest_WB(reg_dest_WB),
    .reg_write_MEM(reg_write_MEM), .reg_write_WB(reg_write_WB),
    .csr_src_EX(csr_src_EX), .csr_dest_MEM(csr_dest_MEM),
    .csr_dest_WB(csr_dest_WB), .csr_write_MEM(csr_write_MEM),
    .csr_write_WB(csr_write_WB),
    .br_EX(br_EX), .jalr_EX(jalr_EX), .jal_ID(jal_ID),
    .md_start_EX(md_start_EX), .dcache_miss(dcache_miss),
    .bubbleF(b1F), .bubbleD(b1D), .bubbleE(b1E),
    .bubbleM(b1M), .bubbleW(b1W),
    .flushF(f1F), .flushD(f1D), .flushE(f1E),
    .flushM(f1M), .flushW(f1W),
    .op1_sel(o1_1), .op2_sel(o1_2), .csr_sel(c1_sel),
    .md_done(md_done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Stall/flush vectors are {F,D,E,M,W}.
  task automatic check_ctl(input string tag, input logic [4:0] exp_bub,
                           input logic [4:0] exp_fl, input logic exp_done);
    check({tag, ".bubble"}, 32'(bub), 32'(exp_bub));
    check({tag, ".flush"},  32'(fl),  32'(exp_fl));
    check({tag, ".md_done"}, 32'(md_done), 32'(exp_done));
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    reg1_src_ID = '0; reg2_src_ID = '0; reg1_read_ID = 0; reg2_read_ID = 0;
    reg1_src_EX = '0; reg2_src_EX = '0; reg_dest_EX = '0; load_EX = 0;
    reg_dest_MEM = '0; reg_dest_WB = '0; reg_write_MEM = 0; reg_write_WB = 0;
    csr_src_EX = '0; csr_dest_MEM = '0; csr_dest_WB = '0;
    csr_write_MEM = 0; csr_write_WB = 0;
    br_EX = 0; jalr_EX = 0; jal_ID = 0; md_start_EX = 0; dcache_miss = 0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    clear_inputs();

    // ---- reset: forwarding condition present but selects must stay 0 ----
    rst = 1;
    reg_write_MEM = 1; reg_dest_MEM = 5'd5; reg1_src_EX = 5'd5;
    sample();
    check_ctl("rst", 5'b00000, 5'b11111, 1'b0);
    check("rst.op1_sel", 32'(op1_sel), 32'd0);
    tick();
    tick();
    rst = 0;
    clear_inputs();

    // ---- forwarding ----
    reg_dest_MEM = 5'd5; reg_write_MEM = 1;
    reg_dest_WB  = 5'd5; reg_write_WB  = 1;
    reg1_src_EX  = 5'd5;
    sample();
    check("fwd.mem_over_wb", 32'(op1_sel), 32'd1);
    check("fwd.op2_x0", 32'(op2_sel), 32'd0);
    check_ctl("fwd.no_stall", 5'b00000, 5'b00000, 1'b0);
    tick();
    reg_write_MEM = 0;
    sample();
    check("fwd.wb", 32'(op1_sel), 32'd2);
    tick();
    reg_dest_MEM = 5'd0; reg_dest_WB = 5'd0;
    sample();
    check("fwd.dest_changed", 32'(op1_sel), 32'd0);
    tick();
    reg1_src_EX = 5'd0; reg_write_MEM = 1; reg_write_WB = 1;
    sample();
    check("fwd.x0_never", 32'(op1_sel), 32'd0);
    tick();
    reg_write_MEM = 0; reg_dest_WB = 5'd9; reg2_src_EX = 5'd9;
    sample();
    check("fwd.op2_wb", 32'(op2_sel), 32'd2);
    tick();
    clear_inputs();
    csr_src_EX = 12'h300; csr_dest_MEM = 12'h300; csr_write_MEM = 1;
    csr_dest_WB = 12'h300; csr_write_WB = 1;
    sample();
    check("csr.mem", 32'(csr_sel), 32'd1);
    tick();
    csr_write_MEM = 0;
    sample();
    check("csr.wb", 32'(csr_sel), 32'd2);
    tick();
    csr_src_EX = 12'h000; csr_dest_MEM = 12'h000; csr_write_MEM = 1;
    sample();
    check("csr.addr0", 32'(csr_sel), 32'd1);
    tick();
    clear_inputs();

    // ---- load-use ----
    load_EX = 1; reg_dest_EX = 5'd7; reg2_src_ID = 5'd7; reg2_read_ID = 1;
    sample();
    check_ctl("lu.hit", 5'b11000, 5'b00100, 1'b0);
    tick();
    // Load has advanced; EX now holds the injected bubble.
    load_EX = 0; reg_dest_EX = 5'd0;
    sample();
    check_ctl("lu.one_cycle", 5'b00000, 5'b00000, 1'b0);
    tick();
    load_EX = 1; reg_dest_EX = 5'd7; reg2_src_ID = 5'd7; reg2_read_ID = 0;
    sample();
    check_ctl("lu.not_read", 5'b00000, 5'b00000, 1'b0);
    tick();
    reg_dest_EX = 5'd0; reg1_src_ID = 5'd0; reg1_read_ID = 1;
    sample();
    check_ctl("lu.x0", 5'b00000, 5'b00000, 1'b0);
    tick();
    clear_inputs();

    // ---- priority ----
    br_EX = 1; load_EX = 1; reg_dest_EX = 5'd3;
    reg1_src_ID = 5'd3; reg1_read_ID = 1;
    sample();
    check_ctl("pri.br_over_lu", 5'b00000, 5'b01100, 1'b0);
    tick();
    br_EX = 0; jalr_EX = 1; load_EX = 0;
    sample();
    check_ctl("pri.jalr", 5'b00000, 5'b01100, 1'b0);
    tick();
    clear_inputs();
    jal_ID = 1;
    sample();
    check_ctl("pri.jal", 5'b00000, 5'b01000, 1'b0);
    tick();
    clear_inputs();
    dcache_miss = 1; br_EX = 1;
    sample();
    check_ctl("pri.miss_over_br", 5'b11110, 5'b00001, 1'b0);
    tick();
    clear_inputs();

    // ---- mul/div, MD_LAT = 4 (and MD_LAT = 1 in parallel) ----
    md_start_EX = 1;
    for (int c = 0; c < 4; c++) begin
      sample();
      if (c < 3)
        check_ctl($sformatf("md.hold%0d", c), 5'b11100, 5'b00010, 1'b0);
      else
        check_ctl("md.release", 5'b00000, 5'b00000, 1'b1);
      check($sformatf("md1.bubble%0d", c), 32'(bub1), 32'd0);
      check($sformatf("md1.flush%0d", c), 32'(fl1), 32'd0);
      check($sformatf("md1.done%0d", c), 32'(md_done1), 32'd0);
      tick();
    end
    md_start_EX = 0;
    sample();
    check_ctl("md.idle_after", 5'b00000, 5'b00000, 1'b0);
    tick();

    // ---- dcache miss during BUSY: release moves from cycle 3 to cycle 5 ----
    md_start_EX = 1;
    for (int c = 0; c < 6; c++) begin
      dcache_miss = (c == 1 || c == 2);
      sample();
      if (c == 1 || c == 2)
        check_ctl($sformatf("mdm.miss%0d", c), 5'b11110, 5'b00001, 1'b0);
      else if (c < 5)
        check_ctl($sformatf("mdm.hold%0d", c), 5'b11100, 5'b00010, 1'b0);
      else
        check_ctl("mdm.release", 5'b00000, 5'b00000, 1'b1);
      tick();
    end
    md_start_EX = 0; dcache_miss = 0;
    sample();
    check_ctl("mdm.idle_after", 5'b00000, 5'b00000, 1'b0);
    tick();

    // ---- reset while BUSY with cnt = 1 ----
    md_start_EX = 1;
    for (int c = 0; c < 2; c++) begin
      sample();
      check_ctl($sformatf("mdr.hold%0d", c), 5'b11100, 5'b00010, 1'b0);
      tick();
    end
    rst = 1;
    sample();
    check_ctl("mdr.in_rst", 5'b00000, 5'b11111, 1'b0);
    tick();
    rst = 0; md_start_EX = 0;
    for (int c = 0; c < 2; c++) begin
      sample();
      check_ctl($sformatf("mdr.after%0d", c), 5'b00000, 5'b00000, 1'b0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the RV32I core. It consumes the register and CSR addresses carried by the ID/EX, EX/MEM and MEM/WB segment registers plus per-stage control flags. It drives the bubbleX/flushX inputs of every segment register (F, D, E, M, W) and the operand/CSR forwarding selects used in EX. Internally it runs a small FSM and down-counter that hold the pipeline for multi-cycle mul/div instructions occupying EX.

## Interface
Parameters:
- MD_LAT, 4: number of cycles a mul/div instruction occupies EX. Legal range is 1..16.

Ports:
- clk  in  1  core clock; all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- reg1_src_ID, reg2_src_ID  in  5  source register addresses in ID
- reg1_read_ID, reg2_read_ID  in  1  the ID instruction actually reads rs1/rs2
- reg1_src_EX, reg2_src_EX, reg_dest_EX  in  5  addresses from the ID/EX register
- load_EX  in  1  the instruction in EX is a load
- reg_dest_MEM, reg_dest_WB  in  5  destination addresses in MEM/WB
- reg_write_MEM, reg_write_WB  in  1  the MEM/WB instruction writes the register file
- csr_src_EX, csr_dest_MEM, csr_dest_WB  in  12  CSR addresses
- csr_write_MEM, csr_write_WB  in  1  the MEM/WB instruction writes a CSR
- br_EX, jalr_EX  in  1  taken branch or jalr resolved in EX
- jal_ID  in  1  jal decoded in ID
- md_start_EX  in  1  a mul/div instruction is in EX
- dcache_miss  in  1  data cache miss in MEM; held high until the data returns
- bubbleF, bubbleD, bubbleE, bubbleM, bubbleW  out  1  hold the corresponding segment register
- flushF, flushD, flushE, flushM, flushW  out  1  zero the corresponding segment register
- op1_sel, op2_sel  out  2  EX operand source: 0 = register file, 1 = MEM ALU result, 2 = WB data
- csr_sel  out  2  EX CSR source: 0 = CSR file, 1 = MEM, 2 = WB
- md_done  out  1  one-cycle pulse marking the release cycle of a mul/div

## Operation
- State: IDLE or BUSY, plus a 4-bit counter cnt. On rst: state = IDLE, cnt = 0.
- While rst is high: all flushX = 1, all bubbleX = 0, md_done = 0, and all selects = 0.
- Stall/flush outputs are combinational from inputs and registered state. When several conditions are active, only the highest-priority one acts:
  1. dcache_miss: bubbleF, bubbleD, bubbleE and bubbleM = 1; flushW = 1. State and cnt are frozen.
  2. mul/div hold. Active when state = BUSY with cnt != 0, or when state = IDLE with md_start_EX = 1 and MD_LAT > 1. Drives bubbleF, bubbleD, bubbleE = 1 and flushM = 1.
  3. br_EX or jalr_EX: flushD = 1, flushE = 1.
  4. Load-use: load_EX = 1, reg_dest_EX != 0, and reg_dest_EX matches a source register that is actually read in ID (reg1_src_ID with reg1_read_ID, or reg2_src_ID with reg2_read_ID). Drives bubbleF = 1, bubbleD = 1, flushE = 1.
  5. jal_ID: flushD = 1.
  6. None of the above: all bubbleX and flushX = 0.
- FSM, evaluated when dcache_miss = 0:
  - IDLE, md_start_EX = 1, MD_LAT > 1: next state BUSY, cnt <= MD_LAT-2.
  - BUSY, cnt != 0: cnt <= cnt-1.
  - BUSY, cnt == 0: no hold, md_done = 1, next state IDLE.
  - Net effect: the mul/div instruction stays in EX for MD_LAT cycles, with MD_LAT-1 stall cycles.
  - MD_LAT = 1: the FSM never leaves IDLE and md_done stays 0.
- Operand forwarding (op1_sel uses reg1_src_EX, op2_sel uses reg2_src_EX):
  - Select MEM (1) if reg_write_MEM = 1, reg_dest_MEM != 0 and reg_dest_MEM equals the source.
  - Otherwise select WB (2) under the same test with the WB signals.
  - Otherwise 0. MEM has priority over WB. x0 is never forwarded.
- CSR forwarding: same rule using csr_write_MEM/WB and csr_dest_MEM/WB against csr_src_EX. There is no x0-style exclusion for CSRs.

## Timing
- Forward selects and stall/flush outputs have zero latency: they are valid in the same cycle as their inputs.
- FSM and cnt update only on posedge clk.
- A reset asserted during BUSY returns the FSM to IDLE with cnt = 0 at the next edge. No md_done is issued for the aborted operation.
- A dcache_miss arriving during BUSY freezes cnt. Counting resumes on the first cycle after dcache_miss drops.
- md_start_EX is still high in the release cycle. Because the FSM is in BUSY in that cycle, this must not restart it.

## Test plan
- Forwarding: reg_dest_MEM = 5, reg_write_MEM = 1, reg_dest_WB = 5, reg_write_WB = 1, reg1_src_EX = 5 -> op1_sel = 1. Then set reg_write_MEM = 0 -> op1_sel = 2. Then change both destinations to 0 -> op1_sel = 0.
- Load-use: load_EX = 1, reg_dest_EX = 7, reg2_src_ID = 7, reg2_read_ID = 1 -> bubbleF = 1, bubbleD = 1, flushE = 1 for exactly one cycle. The same stimulus with reg2_read_ID = 0 -> no stall.
- Mul/div, MD_LAT = 4: md_start_EX held high -> bubbleE = 1 for 3 cycles, md_done = 1 on the 4th cycle, then state returns to IDLE. With MD_LAT = 1 -> no stall and md_done never asserts.
- Priority: br_EX = 1 together with a load-use hit -> only flushD = 1 and flushE = 1; no bubbles. dcache_miss = 1 together with br_EX = 1 -> miss pattern only.
- Miss during BUSY: MD_LAT = 4, dcache_miss held for 2 cycles starting in the first BUSY cycle -> md_done is delayed by exactly 2 cycles and flushW = 1 during the miss.
- Reset mid-BUSY: rst pulsed while cnt = 1 -> all flushes high during rst, state IDLE afterwards, and no md_done pulse.
